// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the ALU-sharing arbiter.
//   ALU_*        : alu_control encodings understood by the shared ALU
//   alu_op_t     : 4-bit alu_control code type
//   is_legal_op  : 1 when the code is one of AND/OR/ADD/SUB/SLT
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_ADD = 4'b0010;
   localparam alu_op_t ALU_SUB = 4'b0110;
   localparam alu_op_t ALU_SLT = 4'b0111;

   function automatic logic is_legal_op(input alu_op_t op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles the requester-side and response-side handshakes of the shared ALU.
//   req_valid/req_ready : per-requester valid/ready
//   req_op/req_a/req_b  : packed per-requester op (4b) and operands (32b)
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id/rsp_data/rsp_illegal : response payload
//   ops_done            : count of completed response handshakes
// master = requesters + response consumer, slave = the arbiter.
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [4*NUM_REQ-1:0]  req_op;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_data;
   logic                  rsp_illegal;
   logic [15:0]           ops_done;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_illegal, ops_done
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_illegal, ops_done
   );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational 32-bit ALU.
//   alu_control : op code (see alu_pkg)
//   a, b        : operands
//   result      : AND / OR / ADD / SUB (mod 2^32) / unsigned SLT; 0 for other codes
// -----------------------------------------------------------------------------
module alu
   import alu_pkg::*;
(
   input  alu_op_t     alu_control,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   // Operation decode; unknown codes yield zero so the illegal flag has a clean payload.
   always_comb begin
      result = 32'd0;
      case (alu_control)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = (a < b) ? 32'd1 : 32'd0;
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick.
//   req       : request vector
//   rr_ptr    : index with highest priority this cycle (register lives in the parent)
//   grant     : one-hot grant, or zero when nothing requests
//   grant_idx : index of the granted requester (0 when none)
//   grant_any : 1 when some requester is granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_any
);

   int              idx_v;
   logic [ID_W-1:0] idx_s;

   // Scan upward from rr_ptr with wrap; the first requester seen wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx_v     = 0;
      idx_s     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v = (int'(rr_ptr) + k) % NUM_REQ;
         idx_s = ID_W'(idx_v);
         if (!grant_any && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
            grant_any    = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a
// registered, 1-cycle-latency response port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of alu_share_arbiter_if (request handshakes in,
//           response + ops_done out)
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   alu_share_arbiter_if.slave bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic              rsp_valid_q,   rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q,      rsp_id_d;
   logic [31:0]       rsp_data_q,    rsp_data_d;
   logic              rsp_illegal_q, rsp_illegal_d;
   logic [15:0]       ops_done_q,    ops_done_d;
   logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;

   logic               out_free_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_idx_s;
   logic               grant_any_s;
   logic               accept_s;
   logic               rsp_hs_s;
   alu_op_t            op_s;
   logic [31:0]        a_s;
   logic [31:0]        b_s;
   logic [31:0]        alu_result_s;

   // The output register can take a new result when empty or being drained this cycle.
   assign out_free_s = !rsp_valid_q | bus.rsp_ready;
   assign rsp_hs_s   = rsp_valid_q & bus.rsp_ready;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (grant_any_s)
   );

   // A grant already implies req_valid, so accept only needs room at the output.
   assign bus.req_ready = grant_s & {NUM_REQ{out_free_s}};
   assign accept_s      = grant_any_s & out_free_s;

   // One-hot AND-OR operand mux; yields zeros when nobody is granted.
   always_comb begin
      op_s = 4'd0;
      a_s  = 32'd0;
      b_s  = 32'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         op_s = op_s | ({4{grant_s[i]}}  & bus.req_op[4*i +: 4]);
         a_s  = a_s  | ({32{grant_s[i]}} & bus.req_a[32*i +: 32]);
         b_s  = b_s  | ({32{grant_s[i]}} & bus.req_b[32*i +: 32]);
      end
   end

   alu u_alu (
      .alu_control (op_s),
      .a           (a_s),
      .b           (b_s),
      .result      (alu_result_s)
   );

   // Next-state for the response register, round-robin pointer and handshake counter.
   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_illegal_d = rsp_illegal_q;
      rr_ptr_d      = rr_ptr_q;
      ops_done_d    = ops_done_q;

      if (accept_s) begin
         // New result replaces the register, even if the old one drains on this edge.
         rsp_valid_d   = 1'b1;
         rsp_id_d      = grant_idx_s;
         rsp_data_d    = alu_result_s;
         rsp_illegal_d = !is_legal_op(op_s);
         rr_ptr_d      = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         // Back-pressure: payload and pointer stay frozen.
         rsp_valid_d = rsp_valid_q;
      end

      if (rsp_hs_s) begin
         ops_done_d = ops_done_q + 16'd1;
      end else begin
         ops_done_d = ops_done_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_data_q    <= 32'd0;
         rsp_illegal_q <= 1'b0;
         ops_done_q    <= 16'd0;
         rr_ptr_q      <= '0;
      end else begin
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         rsp_illegal_q <= rsp_illegal_d;
         ops_done_q    <= ops_done_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_illegal = rsp_illegal_q;
   assign bus.ops_done    = ops_done_q;

endmodule
